// File: rtl/cordic_pkg.sv
// cordic_pkg: Q4.28 angle constants, FSM states and quadrant type
// shared by the CORDIC phase generator and its quadrant fold.
package cordic_pkg;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] HALF_PI       = 32'd421657428;
  localparam logic [WIDTH-1:0] PI            = 32'd843314857;
  localparam logic [WIDTH-1:0] THREE_HALF_PI = 32'd1264972285;
  localparam logic [WIDTH-1:0] TWO_PI        = 32'd1686629713;
  localparam logic [WIDTH-1:0] CORDIC_GAIN   = 32'd163008219;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } phase_gen_state_t;

  typedef logic [1:0] quadrant_t;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// cordic_quadrant_fold: maps a phase in [0, 2pi) to a quadrant,
// the CORDIC start vector and a residual angle in [0, pi/2).
module cordic_quadrant_fold
  import cordic_pkg::*;
#(
  parameter int               width = 32,
  parameter logic [width-1:0] gain  = width'(CORDIC_GAIN)
) (
  input  logic [width-1:0] phase,
  output quadrant_t        quadrant,
  output logic [width-1:0] x,
  output logic [width-1:0] y,
  output logic [width-1:0] angle
);

  localparam logic [width-1:0] HP  = width'(HALF_PI);
  localparam logic [width-1:0] P   = width'(PI);
  localparam logic [width-1:0] THP = width'(THREE_HALF_PI);

  // Boundaries fall into the upper quadrant.
  always_comb begin
    quadrant = 2'd0;
    x        = gain;
    y        = '0;
    angle    = phase;
    unique case (1'b1)
      (phase < HP): begin
        quadrant = 2'd0;
        x        = gain;
        y        = '0;
        angle    = phase;
      end
      (phase >= HP && phase < P): begin
        quadrant = 2'd1;
        x        = '0;
        y        = gain;
        angle    = phase - HP;
      end
      (phase >= P && phase < THP): begin
        quadrant = 2'd2;
        x        = '0 - gain;
        y        = '0;
        angle    = phase - P;
      end
      default: begin
        quadrant = 2'd3;
        x        = '0;
        y        = '0 - gain;
        angle    = phase - THP;
      end
    endcase
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: burst phase accumulator feeding the CORDIC pipeline.
// Optional result alignment under CORDIC_PHASE_GEN_ALIGN_EN.
module cordic_phase_gen #(
  parameter int               width          = 32,
  parameter logic [width-1:0] CORDIC_GAIN    = width'(cordic_pkg::CORDIC_GAIN),
  parameter int               CNT_W          = 16,
  parameter int               CORDIC_LATENCY = 13
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [width-1:0]      freq_word,
  input  logic [width-1:0]      phase_init,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  hold,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [width-1:0]      x_start,
  output logic [width-1:0]      y_start,
  output logic [width-1:0]      angle,
  output cordic_pkg::quadrant_t quadrant,
  output logic                  out_valid
`ifdef CORDIC_PHASE_GEN_ALIGN_EN
  ,
  output logic                  res_valid,
  output logic                  res_last
`endif
);

  import cordic_pkg::*;

  localparam logic [width-1:0] TP = width'(TWO_PI);

  phase_gen_state_t state, state_next;

  logic [width-1:0] phase_q, freq_q;
  logic [CNT_W-1:0] cnt_q;

  logic emit, busy_d, done_d, last_d;

  logic [width:0]   sum;
  logic [width-1:0] phase_nxt, pinit_s, freq_s;

  quadrant_t        f_quad;
  logic [width-1:0] f_x, f_y, f_angle;

  assign last_d = emit && (cnt_q == CNT_W'(1));

  // Inputs may exceed 2pi by less than one turn.
  assign pinit_s = (phase_init >= TP) ? phase_init - TP : phase_init;
  assign freq_s  = (freq_word  >= TP) ? freq_word  - TP : freq_word;

  assign sum       = {1'b0, phase_q} + {1'b0, freq_q};
  assign phase_nxt = (sum >= {1'b0, TP}) ? width'(sum - {1'b0, TP})
                                         : sum[width-1:0];

  cordic_quadrant_fold #(
    .width (width),
    .gain  (CORDIC_GAIN)
  ) u_fold (
    .phase    (phase_q),
    .quadrant (f_quad),
    .x        (f_x),
    .y        (f_y),
    .angle    (f_angle)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start)
              state_next = (num_samples == '0) ? DONE : RUN;
      RUN:  if (abort)
              state_next = IDLE;
            else if (!hold && cnt_q == CNT_W'(1))
              state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    emit   = (state == RUN) && !abort && !hold;
    busy_d = (state == RUN) && !abort;
    done_d = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      freq_q  <= '0;
      cnt_q   <= '0;
    end else if (state == IDLE && start) begin
      phase_q <= pinit_s;
      freq_q  <= freq_s;
      cnt_q   <= num_samples;
    end else if (emit) begin
      phase_q <= phase_nxt;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      x_start   <= CORDIC_GAIN;
      y_start   <= '0;
      angle     <= '0;
      quadrant  <= 2'd0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      out_valid <= emit;
      if (emit) begin
        x_start  <= f_x;
        y_start  <= f_y;
        angle    <= f_angle;
        quadrant <= f_quad;
      end
    end
  end

`ifdef CORDIC_PHASE_GEN_ALIGN_EN
  logic                      last_q;
  logic [CORDIC_LATENCY-1:0] sr_valid, sr_last;

  // Delay line matches the CORDIC's fixed latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= 1'b0;
      sr_valid <= '0;
      sr_last  <= '0;
    end else begin
      last_q <= last_d;
      if (abort && state == RUN) begin
        sr_valid <= '0;
        sr_last  <= '0;
      end else begin
        sr_valid <= {sr_valid[CORDIC_LATENCY-2:0], out_valid};
        sr_last  <= {sr_last[CORDIC_LATENCY-2:0], out_valid && last_q};
      end
    end
  end

  assign res_valid = sr_valid[CORDIC_LATENCY-1];
  assign res_last  = sr_last[CORDIC_LATENCY-1];
`else
  logic unused_last;
  assign unused_last = last_d;
`endif

endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb_cordic_phase_gen: scoreboard bench for cordic_phase_gen.
// Alignment scenario is built only with CORDIC_PHASE_GEN_ALIGN_EN.
module tb_cordic_phase_gen;

  localparam logic [31:0] HP_C   = 32'd421657428;
  localparam logic [31:0] PI_C   = 32'd843314857;
  localparam logic [31:0] THP_C  = 32'd1264972285;
  localparam logic [31:0] TWO_C  = 32'd1686629713;
  localparam logic [31:0] GAIN_C = 32'd163008219;
  localparam logic [31:0] NGAIN  = 32'd0 - GAIN_C;

  logic        clock = 1'b0;
  logic        reset_n, start, hold, abort;
  logic [31:0] freq_word, phase_init;
  logic [15:0] num_samples;
  logic        busy, done, out_valid;
  logic [31:0] x_start, y_start, angle;
  logic [1:0]  quadrant;
`ifdef CORDIC_PHASE_GEN_ALIGN_EN
  logic        res_valid, res_last;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [97:0] sb[$];

  cordic_phase_gen dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .freq_word   (freq_word),
    .phase_init  (phase_init),
    .num_samples (num_samples),
    .hold        (hold),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .x_start     (x_start),
    .y_start     (y_start),
    .angle       (angle),
    .quadrant    (quadrant),
    .out_valid   (out_valid)
`ifdef CORDIC_PHASE_GEN_ALIGN_EN
    ,
    .res_valid   (res_valid),
    .res_last    (res_last)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [97:0] mk(input logic [1:0] q,
                                     input logic [31:0] x, y, a);
    return {q, x, y, a};
  endfunction

  function automatic logic [97:0] fold_m(input logic [31:0] p);
    if (p < HP_C)       return mk(2'd0, GAIN_C, 32'd0, p);
    else if (p < PI_C)  return mk(2'd1, 32'd0, GAIN_C, p - HP_C);
    else if (p < THP_C) return mk(2'd2, NGAIN, 32'd0, p - PI_C);
    else                return mk(2'd3, 32'd0, NGAIN, p - THP_C);
  endfunction

  function automatic logic [31:0] san(input logic [31:0] v);
    return (v >= TWO_C) ? v - TWO_C : v;
  endfunction

  task automatic push_model(input logic [31:0] p0, f0, input int n);
    logic [31:0] p, f;
    logic [32:0] s;
    p = san(p0);
    f = san(f0);
    for (int i = 0; i < n; i++) begin
      sb.push_back(fold_m(p));
      s = {1'b0, p} + {1'b0, f};
      if (s >= {1'b0, TWO_C}) s = s - {1'b0, TWO_C};
      p = s[31:0];
    end
  endtask

  task automatic kick(input logic [31:0] p, f, input logic [15:0] n);
    @(negedge clock);
    phase_init  = p;
    freq_word   = f;
    num_samples = n;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [100:0] want;
    want = {1'b0, 1'b0, 1'b0, 2'd0, GAIN_C, 32'd0, 32'd0};
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({busy, done, out_valid, quadrant, x_start, y_start, angle} !== want) begin
      n_err++;
      $display("FAIL reset_in: got %h want %h",
               {busy, done, out_valid, quadrant, x_start, y_start, angle}, want);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({busy, done, out_valid, quadrant, x_start, y_start, angle} !== want) begin
      n_err++;
      $display("FAIL reset_after: got %h want %h",
               {busy, done, out_valid, quadrant, x_start, y_start, angle}, want);
    end
  endtask

  task automatic test_quadrants();
    int nv = 0, dc = -1;
    logic [97:0] e;
    push_model(32'd0, HP_C, 4);
    kick(32'd0, HP_C, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL quad_busy: got %b want 1", busy);
        end
      end
      if (out_valid) begin
        nv++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL quad_sample c%0d: got %h want %h", c,
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (done && dc < 0) begin
        dc = c; n_cmp++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL quad_busy_done: got %b want 0", busy);
        end
      end
    end
    n_cmp++;
    if (nv != 4 || dc != 5) begin
      n_err++; $display("FAIL quad_count: got nv=%0d done=%0d want 4/5", nv, dc);
    end
  endtask

  task automatic test_wrap();
    int nv = 0, dc = -1;
    logic [97:0] e;
    sb.push_back(mk(2'd3, 32'd0, NGAIN, HP_C - 32'd10));
    sb.push_back(mk(2'd0, GAIN_C, 32'd0, 32'd10));
    kick(TWO_C - 32'd10, 32'd20, 16'd2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (out_valid) begin
        nv++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL wrap_sample c%0d: got %h want %h", c,
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (done && dc < 0) dc = c;
    end
    n_cmp++;
    if (nv != 2 || dc != 3) begin
      n_err++; $display("FAIL wrap_count: got nv=%0d done=%0d want 2/3", nv, dc);
    end
  endtask

  task automatic test_pi_boundary();
    int nv = 0, dc = -1;
    logic [97:0] e;
    sb.push_back(mk(2'd2, NGAIN, 32'd0, 32'd0));
    kick(PI_C, 32'd123, 16'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (out_valid) begin
        nv++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL pi_sample: got %h want %h",
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (done && dc < 0) dc = c;
    end
    n_cmp++;
    if (nv != 1 || dc != 2) begin
      n_err++; $display("FAIL pi_count: got nv=%0d done=%0d want 1/2", nv, dc);
    end
  endtask

  task automatic test_sanitize();
    int nv = 0, dc = -1;
    logic [97:0] e;
    sb.push_back(mk(2'd0, GAIN_C, 32'd0, 32'd5));
    sb.push_back(mk(2'd1, 32'd0, GAIN_C, 32'd5));
    kick(TWO_C + 32'd5, TWO_C + HP_C, 16'd2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (out_valid) begin
        nv++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL san_sample c%0d: got %h want %h", c,
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (done && dc < 0) dc = c;
    end
    n_cmp++;
    if (nv != 2 || dc != 3) begin
      n_err++; $display("FAIL san_count: got nv=%0d done=%0d want 2/3", nv, dc);
    end
  endtask

  task automatic test_hold();
    int nv = 0, dc = -1;
    logic [97:0] e;
    push_model(32'd100, 32'd300000000, 8);
    kick(32'd100, 32'd300000000, 16'd8);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL hold_valid c%0d: got %b want 0", c, out_valid);
        end
      end
      if (out_valid) begin
        nv++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL hold_sample c%0d: got %h want %h", c,
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (done && dc < 0) dc = c;
      if (c == 1) begin
        start = 1'b1; num_samples = '0; phase_init = PI_C;
      end
      if (c == 2) begin
        start = 1'b0; hold = 1'b1;
      end
      if (c == 5) hold = 1'b0;
    end
    n_cmp++;
    if (nv != 8 || dc != 12 || sb.size() != 0) begin
      n_err++;
      $display("FAIL hold_count: got nv=%0d done=%0d left=%0d want 8/12/0",
               nv, dc, sb.size());
    end
  endtask

  task automatic test_abort();
    int nv = 0, dc = -1;
    logic [97:0] e;
    push_model(32'd0, 32'd50000000, 10);
    kick(32'd0, 32'd50000000, 16'd10);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (c == 4) begin
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL abort_idle: got busy=%b valid=%b want 0/0", busy, out_valid);
        end
      end
      if (out_valid) begin
        nv++; n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL abort_sample c%0d: got %h want %h", c,
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (done && dc < 0) dc = c;
      if (c == 2) abort = 1'b1;
      if (c == 3) abort = 1'b0;
    end
    n_cmp++;
    if (nv != 2 || dc != -1 || sb.size() != 8) begin
      n_err++;
      $display("FAIL abort_count: got nv=%0d done=%0d left=%0d want 2/-1/8",
               nv, dc, sb.size());
    end
    sb.delete();
    nv = 0; dc = -1;
    kick(32'd0, 32'd0, 16'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (out_valid) nv++;
      if (done && dc < 0) dc = c;
    end
    n_cmp++;
    if (nv != 0 || dc != 1) begin
      n_err++; $display("FAIL zero_burst: got nv=%0d done=%0d want 0/1", nv, dc);
    end
  endtask

`ifdef CORDIC_PHASE_GEN_ALIGN_EN
  task automatic test_align();
    int ov[$];
    int rv[$];
    int nl = 0, lc = -1;
    logic [97:0] e;
    push_model(32'd7, 32'd1000, 3);
    kick(32'd7, 32'd1000, 16'd3);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      if (out_valid) begin
        ov.push_back(c); n_cmp++;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        if ({quadrant, x_start, y_start, angle} !== e) begin
          n_err++;
          $display("FAIL align_sample c%0d: got %h want %h", c,
                   {quadrant, x_start, y_start, angle}, e);
        end
      end
      if (res_valid) rv.push_back(c);
      if (res_last) begin nl++; lc = c; end
    end
    n_cmp++;
    if (rv.size() != 3 || ov.size() != 3) begin
      n_err++;
      $display("FAIL align_count: got res=%0d out=%0d want 3/3", rv.size(), ov.size());
    end
    for (int i = 0; i < rv.size() && i < ov.size(); i++) begin
      n_cmp++;
      if (rv[i] != ov[i] + 13) begin
        n_err++; $display("FAIL align_delay %0d: got %0d want %0d", i, rv[i], ov[i] + 13);
      end
    end
    n_cmp++;
    if (ov.size() != 3 || nl != 1 || lc != ov[2] + 13) begin
      n_err++; $display("FAIL align_last: got n=%0d c=%0d want 1 on third", nl, lc);
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [100:0] want;
    want = {1'b0, 1'b0, 1'b0, 2'd0, GAIN_C, 32'd0, 32'd0};
    push_model(32'd0, HP_C, 5);
    kick(32'd0, HP_C, 16'd5);
    repeat (2) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL areset_pre: got %b want 1", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, out_valid, quadrant, x_start, y_start, angle} !== want) begin
      n_err++;
      $display("FAIL areset_now: got %h want %h",
               {busy, done, out_valid, quadrant, x_start, y_start, angle}, want);
    end
    @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_idle: got busy=%b valid=%b want 0/0", busy, out_valid);
    end
  endtask

  initial begin
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    freq_word = '0; phase_init = '0; num_samples = '0;
    test_reset();
    test_quadrants();
    test_wrap();
    test_pi_boundary();
    test_sanitize();
    test_hold();
    test_abort();
`ifdef CORDIC_PHASE_GEN_ALIGN_EN
    test_align();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
